front_panel_wb_master: RTL

- Wishbone pipelined bus master driven by the IMSAI front-panel EXAMINE / EXAMINE NEXT / DEPOSIT / DEPOSIT NEXT switches.
- Sits directly upstream of the system RAM slave. Turns one-cycle panel command pulses into single Wishbone read/write transactions.
- Holds the panel address register and drives the address/data LED registers.
- Includes a bus timeout so a missing slave cannot hang the panel.

---
 rtl/front_panel_wb_master.sv | 130 +++++++++++++
 1 files changed

// File: rtl/front_panel_wb_master.sv
// rtl/front_panel_wb_master.sv - front-panel switch commands to single Wishbone pipelined transactions
module front_panel_wb_master #(
  parameter int WIDTH          = 8,
  parameter int ADDR_LINES     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_run,
  input  logic                  i_cmd_examine,
  input  logic                  i_cmd_examine_next,
  input  logic                  i_cmd_deposit,
  input  logic                  i_cmd_deposit_next,
  input  logic [ADDR_LINES-1:0] i_addr_sw,
  input  logic [WIDTH-1:0]      i_data_sw,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADDR_LINES-1:0] o_wb_addr,
  output logic [WIDTH-1:0]      o_wb_data,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_stall,
  input  logic [WIDTH-1:0]      i_wb_data,
  output logic [ADDR_LINES-1:0] o_addr_led,
  output logic [WIDTH-1:0]      o_data_led,
  output logic                  o_busy,
  output logic                  o_timeout
);

  // Counter must hold TIMEOUT_CYCLES itself, since it increments on the aborting cycle too.
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ACK
  } state_t;

  state_t                state;
  logic [CW-1:0]         tmo_cnt;
  logic [ADDR_LINES-1:0] addr_reg;

  logic                  any_cmd;
  logic                  cmd_write;
  logic [ADDR_LINES-1:0] new_addr;

  assign o_addr_led = addr_reg;

  // Decode the highest-priority panel pulse into direction and target address.
  always_comb begin
    any_cmd   = i_cmd_examine | i_cmd_examine_next | i_cmd_deposit | i_cmd_deposit_next;
    cmd_write = 1'b0;
    new_addr  = addr_reg;
    if (i_cmd_examine) begin
      new_addr = i_addr_sw;
    end else if (i_cmd_examine_next) begin
      new_addr = addr_reg + ADDR_LINES'(1);
    end else if (i_cmd_deposit) begin
      cmd_write = 1'b1;
    end else if (i_cmd_deposit_next) begin
      cmd_write = 1'b1;
      new_addr  = addr_reg + ADDR_LINES'(1);
    end
  end

  // Bus FSM: accept a command, present the strobe until not stalled, then await ack or timeout.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      tmo_cnt    <= '0;
      addr_reg   <= '0;
      o_wb_cyc   <= 1'b0;
      o_wb_stb   <= 1'b0;
      o_wb_we    <= 1'b0;
      o_wb_addr  <= '0;
      o_wb_data  <= '0;
      o_data_led <= '0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!i_run && any_cmd) begin
            addr_reg  <= new_addr;
            o_wb_addr <= new_addr;
            o_wb_we   <= cmd_write;
            o_wb_data <= i_data_sw;
            o_timeout <= 1'b0;
            tmo_cnt   <= '0;
            o_wb_cyc  <= 1'b1;
            o_wb_stb  <= 1'b1;
            o_busy    <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          tmo_cnt <= tmo_cnt + CW'(1);
          if (tmo_cnt == CNT_LAST) begin
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_busy    <= 1'b0;
            o_timeout <= 1'b1;
            state     <= S_IDLE;
          end else if (!i_wb_stall) begin
            o_wb_stb <= 1'b0;
            state    <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          tmo_cnt <= tmo_cnt + CW'(1);
          // An ack on the final counted cycle still completes normally.
          if (i_wb_ack) begin
            o_data_led <= o_wb_we ? o_wb_data : i_wb_data;
            o_wb_cyc   <= 1'b0;
            o_busy     <= 1'b0;
            state      <= S_IDLE;
          end else if (tmo_cnt == CNT_LAST) begin
            o_wb_cyc  <= 1'b0;
            o_busy    <= 1'b0;
            o_timeout <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
